csel_nibble_subtractor: RTL and testbench

- Multi-cycle unsigned subtractor that computes diff = a - b - bin, one 4-bit nibble per clock, LSB nibble first.
- Each nibble is formed carry-select style: both borrow-in cases are precomputed, and the registered borrow picks one.
- It is the reverse-direction companion to the team's carry-select adder and consumes operands on a valid/ready handshake.
- Sits in the datapath between the operand registers and the result consumer.

---
 rtl/csel_nibble_subtractor_pkg.sv | 19 +
 rtl/csel_nibble_subtractor_nibble.sv | 35 +++
 rtl/csel_nibble_subtractor.sv | 112 +++++++++++
 tb/tb_csel_nibble_subtractor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csel_nibble_subtractor_pkg.sv
// Shared types and helpers for the carry-select nibble subtractor.
package csel_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csub_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/csel_nibble_subtractor_nibble.sv
// Combinational 4-bit dual-borrow subtractor: both borrow-in cases are
// rippled in parallel and the incoming borrow selects one.
module csub_nibble
    import csel_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_n,
    input  logic [NIBBLE_W-1:0] b_n,
    input  logic                sel_borrow,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo
);

    logic [NIBBLE_W-1:0] d0;
    logic [NIBBLE_W-1:0] d1;
    logic [NIBBLE_W:0]   c0;
    logic [NIBBLE_W:0]   c1;

    always_comb begin
        d0    = '0;
        d1    = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < NIBBLE_W; i++) begin
            d0[i]   = a_n[i] ^ b_n[i] ^ c0[i];
            c0[i+1] = (~a_n[i] & b_n[i]) | (~(a_n[i] ^ b_n[i]) & c0[i]);
            d1[i]   = a_n[i] ^ b_n[i] ^ c1[i];
            c1[i+1] = (~a_n[i] & b_n[i]) | (~(a_n[i] ^ b_n[i]) & c1[i]);
        end
    end

    assign d  = sel_borrow ? d1 : d0;
    assign bo = sel_borrow ? c1[NIBBLE_W] : c0[NIBBLE_W];

endmodule

// File: rtl/csel_nibble_subtractor.sv
// Multi-cycle unsigned subtractor, diff = a - b - bin, one nibble per clock.
// Define CSUB_OVERFLOW_EN to add the signed-overflow output ovf.
//
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | computing nibble k, LSB first
//   DONE  | result held until out_ready
module csel_nibble_subtractor
    import csel_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef CSUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int IW = (NIBBLES > 1) ? clog2(NIBBLES) : 1;

    csub_state_t         state;
    csub_state_t         state_nxt;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        diff_q;
    logic                borrow_q;
    logic [IW-1:0]       k_q;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_d;
    logic                nib_bo;
    logic                last_nib;

    assign last_nib = (k_q == IW'(NIBBLES - 1));
    assign nib_a    = NIBBLE_W'(a_q >> (NIBBLE_W * k_q));
    assign nib_b    = NIBBLE_W'(b_q >> (NIBBLE_W * k_q));

    csub_nibble u_nibble (
        .a_n        (nib_a),
        .b_n        (nib_b),
        .sel_borrow (borrow_q),
        .d          (nib_d),
        .bo         (nib_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    borrow_q <= bin;
                    diff_q   <= '0;
                    k_q      <= '0;
                end
                RUN: begin
                    // diff was cleared on accept, so OR-ing places the nibble
                    diff_q   <= diff_q | (W'(nib_d) << (NIBBLE_W * k_q));
                    borrow_q <= nib_bo;
                    k_q      <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = borrow_q;

`ifdef CSUB_OVERFLOW_EN
    assign ovf = (state == DONE) && (a_q[W-1] != b_q[W-1]) && (diff_q[W-1] != a_q[W-1]);
`endif

endmodule

// File: tb/tb_csel_nibble_subtractor.sv
// Scoreboard bench for csel_nibble_subtractor (NIBBLES=4).
module tb_csel_nibble_subtractor;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
`ifdef CSUB_OVERFLOW_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csel_nibble_subtractor #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CSUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t         e;
        logic [W:0]   r;
        r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.diff = r[W-1:0];
        e.bout = r[W];
        e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return e;
    endfunction

    // Compare each result when it is handed over to the consumer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_depth", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", diff, e.diff);
                chk("bout", bout, e.bout);
`ifdef CSUB_OVERFLOW_EN
                chk("ovf", ovf, e.ovf);
`endif
            end
        end
    end

    // Drive one operation, return cycles from accept to out_valid.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output int lat);
        int waited;
        lat    = 0;
        waited = 0;
        @(posedge clk); #1;
        a = x; b = y; bin = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", waited, 0);
        @(posedge clk);
        sb.push_back(model(x, y, c));
        #1;
        in_valid = 1'b0;
        a = ~x; b = ~y; bin = ~c;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) chk("done_timeout", lat, NIB);
    endtask

    initial begin
        int   lat;
        logic [W-1:0] d_hold;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        #1 rst_n = 1'b1;

        out_ready = 1'b1;
        send(16'h1234, 16'h0234, 1'b0, lat);
        chk("latency", lat, NIB);
        @(negedge clk);
        chk("valid_one_cycle", out_valid, 0);
        chk("sb_drained_1", sb.size(), 0);

        send(16'h0000, 16'h0001, 1'b0, lat);
        chk("latency_2", lat, NIB);
        send(16'h8000, 16'h8000, 1'b1, lat);
        send(16'h7FFF, 16'hFFFF, 1'b0, lat);
        send(16'h0005, 16'h0003, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), lat);
            chk("latency_rand", lat, NIB);
        end
        @(negedge clk);
        chk("sb_drained_2", sb.size(), 0);

        // Backpressure: hold DONE and try to push a second operation.
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h00FF, 16'h000F, 1'b0, lat);
        #1 in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        d_hold = diff;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, 16'h00F0);
            chk("bp_diff_stable", diff, d_hold);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_sb_drained", sb.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_extra", out_valid, 0);
        end

        // Reset two cycles into RUN discards the operation.
        @(posedge clk); #1;
        a = 16'hABCD; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_bout", bout, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        send(16'h0005, 16'h0003, 1'b0, lat);
        chk("post_rst_latency", lat, NIB);
        @(negedge clk);
        chk("sb_drained_3", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
